// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, register-zero id and
// the writeback-hit test used by the operand bypass and by the hold snoop.
package pipe_pkg;

  localparam int unsigned CTRL_W         = 8;
  localparam int unsigned REG_AW         = 5;
  localparam int unsigned CTRL_MEM_READ  = 0;
  localparam int unsigned CTRL_REG_WRITE = 1;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // True when writeback updates register ra; x0 never matches.
  function automatic logic wb_hit(input logic              we,
                                  input logic [REG_AW-1:0] wa,
                                  input logic [REG_AW-1:0] ra);
    return we && (wa != REG_ZERO) && (wa == ra);
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard detection between the
// instruction held in execute and the instruction currently in decode.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rd_i       - instruction held in execute
//   id_rs1_i/id_use_rs1_i, id_rs2_i/id_use_rs2_i - decode source operands
//   luh_o                                    - hazard, decode must wait
module load_use_detect
  import pipe_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic              id_use_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs2_i,
  output logic              luh_o
);

  logic src_match;

  always_comb begin
    src_match = (id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                (id_use_rs2_i && (id_rs2_i == ex_rd_i));
    luh_o     = ex_valid_i && ex_mem_read_i && (ex_rd_i != REG_ZERO) && src_match;
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with valid/ready
// handshake, flush, one-cycle load-use bubble, same-cycle writeback bypass
// and writeback snooping of held operands.
// Ports:
//   clk, rst (async, active-low)
//   in_*     - decode side: instruction fields, operands, in_valid/in_ready
//   wb_*     - writeback port (same one that writes the register file)
//   flush    - kills held and incoming instruction
//   out_*    - execute side: registered fields, out_valid/out_ready
// Optional (macro ID_EX_PERF_EN): stall_cnt, bubble_cnt performance counters.
module id_ex_stage #(
  parameter int unsigned N      = 32,
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_pc,
  input  logic [N-1:0]      in_imm,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [N-1:0]      in_rs1_data,
  input  logic [N-1:0]      in_rs2_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              wb_RegWrite,
  input  logic [4:0]        wb_addr,
  input  logic [N-1:0]      wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_pc,
  output logic [N-1:0]      out_imm,
  output logic [N-1:0]      out_op1,
  output logic [N-1:0]      out_op2,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  import pipe_pkg::*;

  logic              valid_q, valid_d;
  logic [N-1:0]      pc_q, pc_d, imm_q, imm_d, op1_q, op1_d, op2_q, op2_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic              adv, luh;
  logic [N-1:0]      op1_byp, op2_byp;

  load_use_detect u_luh (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q[CTRL_MEM_READ]),
    .ex_rd_i       (rd_q),
    .id_rs1_i      (in_rs1),
    .id_use_rs1_i  (in_use_rs1),
    .id_rs2_i      (in_rs2),
    .id_use_rs2_i  (in_use_rs2),
    .luh_o         (luh)
  );

  // Handshake and same-cycle writeback bypass of register-file reads.
  always_comb begin
    adv      = !valid_q || out_ready;
    in_ready = adv && !luh && !flush;
    op1_byp  = wb_hit(wb_RegWrite, wb_addr, in_rs1) ? wb_data : in_rs1_data;
    op2_byp  = wb_hit(wb_RegWrite, wb_addr, in_rs2) ? wb_data : in_rs2_data;
  end

  // Next-state: flush > bubble > load > drain > hold-with-snoop.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv) begin
      if (luh || !in_valid) begin
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b1;
        pc_d    = in_pc;
        imm_d   = in_imm;
        op1_d   = op1_byp;
        op2_d   = op2_byp;
        rs1_d   = in_rs1;
        rs2_d   = in_rs2;
        rd_d    = in_rd;
        ctrl_d  = in_ctrl;
      end
    end else begin
      // Held operands track writeback so they are current when released.
      if (wb_hit(wb_RegWrite, wb_addr, rs1_q)) op1_d = wb_data;
      if (wb_hit(wb_RegWrite, wb_addr, rs2_q)) op2_d = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_imm   = imm_q;
  assign out_op1   = op1_q;
  assign out_op2   = op2_q;
  assign out_rs1   = rs1_q;
  assign out_rs2   = rs2_q;
  assign out_rd    = rd_q;
  assign out_ctrl  = ctrl_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_q, bubble_q;

  // Stall: decode waiting without being flushed. Bubble: load-use slot inserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (in_valid && !in_ready && !flush) stall_q  <= stall_q + 32'd1;
      if (!flush && adv && luh)            bubble_q <= bubble_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int unsigned N  = 32;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [N-1:0]  in_pc, in_imm, in_rs1_data, in_rs2_data;
  logic [4:0]    in_rs1, in_rs2, in_rd;
  logic          in_use_rs1, in_use_rs2;
  logic [CW-1:0] in_ctrl;
  logic          wb_RegWrite;
  logic [4:0]    wb_addr;
  logic [N-1:0]  wb_data;
  logic          flush;
  logic          out_valid, out_ready;
  logic [N-1:0]  out_pc, out_imm, out_op1, out_op2;
  logic [4:0]    out_rs1, out_rs2, out_rd;
  logic [CW-1:0] out_ctrl;
`ifdef ID_EX_PERF_EN
  logic [31:0]   stall_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.N(N), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_ctrl(in_ctrl),
    .wb_RegWrite(wb_RegWrite), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_op1(out_op1), .out_op2(out_op2),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_ctrl(out_ctrl)
`ifdef ID_EX_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct packed {
    logic [N-1:0]  pc;
    logic [N-1:0]  imm;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic          use1;
    logic          use2;
    logic [CW-1:0] ctrl;
  } instr_t;

  // Reference: architectural register file plus the instruction occupying the stage.
  logic [N-1:0] rf [32];
  instr_t       cur;
  logic         m_valid;
  instr_t       m_slot;
  logic [31:0]  m_stall, m_bubble;

  int unsigned  n_assert = 0;
  int unsigned  n_fail   = 0;
  logic         obs_ready;
  int unsigned  vcount;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic [4:0] rs1, input logic use1,
                                input logic [4:0] rs2, input logic use2,
                                input logic [4:0] rd, input logic [CW-1:0] ctrl);
    instr_t t;
    t.pc   = $urandom;
    t.imm  = $urandom;
    t.rs1  = rs1;
    t.rs2  = rs2;
    t.rd   = rd;
    t.use1 = use1;
    t.use2 = use2;
    t.ctrl = ctrl;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    logic [CW-1:0] c;
    c = CW'($urandom);
    return mk(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
              1'($urandom), 5'($urandom_range(0, 7)), c);
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_stall  = '0;
    m_bubble = '0;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("fields", {out_pc, out_imm, out_rs1, out_rs2, out_rd, out_ctrl},
          {m_slot.pc, m_slot.imm, m_slot.rs1, m_slot.rs2, m_slot.rd, m_slot.ctrl});
      // Bypass and snoop keep held operands equal to the current register file.
      chk("out_op1", out_op1, rf[m_slot.rs1]);
      chk("out_op2", out_op2, rf[m_slot.rs2]);
    end
`ifdef ID_EX_PERF_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("bubble_cnt", bubble_cnt, m_bubble);
`endif
  endtask

  // One clock: drive decode from cur/rf, check in_ready, clock, update model, check outputs.
  task automatic step();
    logic hz, adv, exp_ready;
    in_pc       = cur.pc;
    in_imm      = cur.imm;
    in_rs1      = cur.rs1;
    in_rs2      = cur.rs2;
    in_rd       = cur.rd;
    in_use_rs1  = cur.use1;
    in_use_rs2  = cur.use2;
    in_ctrl     = cur.ctrl;
    in_rs1_data = rf[cur.rs1];
    in_rs2_data = rf[cur.rs2];
    #1;
    hz  = m_valid && m_slot.ctrl[0] && (m_slot.rd != 5'd0) &&
          ((cur.use1 && cur.rs1 == m_slot.rd) || (cur.use2 && cur.rs2 == m_slot.rd));
    adv = !m_valid || out_ready;
    exp_ready = adv && !hz && !flush;
    obs_ready = in_ready;
    chk("in_ready", in_ready, exp_ready);
    @(posedge clk);
    if (in_valid && !exp_ready && !flush) m_stall = m_stall + 32'd1;
    if (!flush && adv && hz)              m_bubble = m_bubble + 32'd1;
    if (flush)                       m_valid = 1'b0;
    else if (adv && in_valid && !hz) begin m_valid = 1'b1; m_slot = cur; end
    else if (adv)                    m_valid = 1'b0;
    if (wb_RegWrite && wb_addr != 5'd0) rf[wb_addr] = wb_data;
    #1;
    check_outputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : N'($urandom);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    wb_RegWrite = 1'b0; wb_addr = '0; wb_data = '0;
    cur = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_outs", {out_pc, out_imm, out_op1, out_op2, out_rs1, out_rs2, out_rd, out_ctrl}, '0);
    @(negedge clk);
    rst = 1'b1;

    // Basic capture, then asynchronous reset in mid-cycle.
    rf[3] = 32'h11;
    cur = mk(5'd3, 1'b1, 5'd0, 1'b0, 5'd1, 8'h02);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("basic_op1", out_op1, 32'h11);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_outs", {out_pc, out_imm, out_op1, out_op2, out_rs1, out_rs2, out_rd, out_ctrl}, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    step();

    // Same-cycle writeback bypass, and x0 is never bypassed.
    rf[5] = 32'h0;
    cur = mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd2, 8'h02);
    in_valid = 1'b1;
    wb_RegWrite = 1'b1; wb_addr = 5'd5; wb_data = 32'hABCD;
    step();
    chk("bypass_op1", out_op1, 32'hABCD);
    cur = mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 8'h02);
    wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    step();
    chk("x0_no_bypass", out_op1, 32'h0);
    wb_RegWrite = 1'b0;

    // Load-use: one bubble, then the consumer is accepted.
    cur = mk(5'd1, 1'b1, 5'd2, 1'b0, 5'd7, 8'h03);
    step();
    cur = mk(5'd3, 1'b0, 5'd7, 1'b1, 5'd8, 8'h02);
    step();
    chk("luh_ready", obs_ready, 1'b0);
    chk("luh_bubble", out_valid, 1'b0);
`ifdef ID_EX_PERF_EN
    chk("luh_bubble_cnt", bubble_cnt, 32'd1);
`endif
    step();
    chk("luh_accept_ready", obs_ready, 1'b1);
    chk("luh_accept_rs2", out_rs2, 5'd7);

    // Hold for three cycles while writeback updates the held source.
    cur = mk(5'd9, 1'b1, 5'd4, 1'b1, 5'd10, 8'h02);
    step();
    out_ready = 1'b0;
    cur = mk(5'd11, 1'b1, 5'd12, 1'b1, 5'd13, 8'h02);
    for (int c = 0; c < 3; c++) begin
      wb_RegWrite = (c == 1); wb_addr = 5'd9; wb_data = 32'h55;
      step();
      chk("hold_ready", obs_ready, 1'b0);
    end
    wb_RegWrite = 1'b0;
    chk("hold_snoop_op1", out_op1, 32'h55);

    // Flush with held and incoming instruction.
    flush = 1'b1;
    step();
    chk("flush_ready", obs_ready, 1'b0);
    chk("flush_valid", out_valid, 1'b0);
    flush = 1'b0; out_ready = 1'b1;
    cur = mk(5'd1, 1'b0, 5'd2, 1'b0, 5'd4, 8'h03);
    step();
    cur = mk(5'd4, 1'b1, 5'd2, 1'b0, 5'd6, 8'h02);
    flush = 1'b1;
    step();
    chk("flush_luh_valid", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0;
    step();

    // Stream of independent instructions at full rate.
    in_valid = 1'b1; vcount = 0;
    for (int k = 0; k < 10; k++) begin
      cur = mk(5'($urandom_range(0, 31)), 1'b1, 5'($urandom_range(0, 31)), 1'b1,
               5'($urandom_range(1, 31)), 8'h02);
      step();
      if (out_valid) vcount++;
    end
    in_valid = 1'b0;
    step();
    chk("stream_count", vcount, 10);
    chk("stream_drain", out_valid, 1'b0);

    // Randomized traffic against the reference.
    for (int k = 0; k < 400; k++) begin
      cur         = rand_instr();
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 9) == 0);
      wb_RegWrite = 1'($urandom);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = N'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
